// File: rtl/img_pkg.sv
// Shared image-pipeline constants, read FSM states and the window row-enable helper.
// Used by the line buffer bank, the scheduler and the edge kernels.
package img_pkg;

    localparam int LINE_WIDTH = 512;
    localparam int NUM_BUFS   = 4;
    localparam int ADDR_W     = $clog2(LINE_WIDTH);
    localparam int BUF_W      = $clog2(NUM_BUFS);
    localparam int FILL_W     = $clog2(NUM_BUFS * LINE_WIDTH) + 1;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_e;

    // Three consecutive rows starting at the top-row buffer, wrapping around the bank.
    function automatic logic [NUM_BUFS-1:0] rotl_rows(input logic [BUF_W-1:0] top);
        logic [2*NUM_BUFS-1:0] dbl;
        dbl = {{NUM_BUFS{1'b0}}, NUM_BUFS'(4'b0111)} << top;
        return dbl[2*NUM_BUFS-1:NUM_BUFS] | dbl[NUM_BUFS-1:0];
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// (buffer index, pixel address) pointer into the line-buffer ring.
// Advances on en; the address wraps at the line end and carries into the buffer index.
module ring_ptr
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [BUF_W-1:0]  o_buf,
    output logic [ADDR_W-1:0] o_addr
);

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        buf_d  = buf_q;
        addr_d = addr_q;
        if (en) begin
            if (addr_q == ADDR_W'(LINE_WIDTH - 1)) begin
                addr_d = '0;
                buf_d  = (buf_q == BUF_W'(NUM_BUFS - 1)) ? '0 : buf_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            addr_q <= '0;
        end else begin
            buf_q  <= buf_d;
            addr_q <= addr_d;
        end
    end

    assign o_buf  = buf_q;
    assign o_addr = addr_q;

endmodule

// File: rtl/line_buffer_sched.sv
// Sequences writes into the four-line buffer bank and reads out three-row windows
// once three lines are stored; pulses o_intr after each completed output line.
module line_buffer_sched
    import img_pkg::*;
(
    input  logic                axi_clk,
    input  logic                axi_reset,
    input  logic                i_pixel_valid,
    output logic                o_in_ready,
    output logic [NUM_BUFS-1:0] o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    input  logic                i_out_ready,
    output logic [NUM_BUFS-1:0] o_rd_en,
    output logic [ADDR_W-1:0]   o_rd_addr,
    output logic [BUF_W-1:0]    o_rd_sel,
    output logic                o_window_valid,
    output logic                o_intr
);

    localparam logic [FILL_W-1:0] FILL_CAP   = FILL_W'(NUM_BUFS * LINE_WIDTH);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * LINE_WIDTH);

    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    rd_state_e         state_q, state_d;
    logic              win_vld_q, win_vld_d;
    logic              intr_q, intr_d;

    logic              wr_acc, rd_beat, rd_last;
    logic [BUF_W-1:0]  wr_buf, rd_buf;

    assign o_in_ready = (fill_cnt_q < FILL_CAP);
    assign wr_acc     = i_pixel_valid && o_in_ready;
    assign rd_beat    = (state_q == RD_ACTIVE) && i_out_ready;
    assign rd_last    = (o_rd_addr == ADDR_W'(LINE_WIDTH - 1));

    ring_ptr u_wr_ptr (
        .clk    (axi_clk),
        .rst    (axi_reset),
        .en     (wr_acc),
        .o_buf  (wr_buf),
        .o_addr (o_wr_addr)
    );

    ring_ptr u_rd_ptr (
        .clk    (axi_clk),
        .rst    (axi_reset),
        .en     (rd_beat),
        .o_buf  (rd_buf),
        .o_addr (o_rd_addr)
    );

    always_comb begin
        o_wr_en = '0;
        if (wr_acc) o_wr_en[wr_buf] = 1'b1;
        o_rd_en  = rd_beat ? rotl_rows(rd_buf) : '0;
        o_rd_sel = rd_buf;
    end

    // Capping fill_cnt at the bank size keeps writes from overtaking the read row.
    always_comb begin
        fill_cnt_d = fill_cnt_q + FILL_W'(wr_acc) - FILL_W'(rd_beat);
        win_vld_d  = rd_beat;
        intr_d     = rd_beat && rd_last;
        state_d    = state_q;
        case (state_q)
            RD_IDLE:   if (fill_cnt_q >= FILL_START) state_d = RD_ACTIVE;
            RD_ACTIVE: if (rd_beat && rd_last)       state_d = RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            fill_cnt_q <= '0;
            state_q    <= RD_IDLE;
            win_vld_q  <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            state_q    <= state_d;
            win_vld_q  <= win_vld_d;
            intr_q     <= intr_d;
        end
    end

    assign o_window_valid = win_vld_q;
    assign o_intr         = intr_q;

endmodule

// File: tb/tb_line_buffer_sched.sv
// Bench for line_buffer_sched: reset/table vectors, directed line sequences and random
// traffic, all checked against a pixel-count reference model.
module tb_line_buffer_sched;
    import img_pkg::*;

    localparam int LW = LINE_WIDTH;

    logic                axi_clk = 1'b0;
    logic                axi_reset = 1'b0;
    logic                i_pixel_valid = 1'b0;
    logic                i_out_ready = 1'b0;
    logic                o_in_ready;
    logic [3:0]          o_wr_en;
    logic [ADDR_W-1:0]   o_wr_addr;
    logic [3:0]          o_rd_en;
    logic [ADDR_W-1:0]   o_rd_addr;
    logic [1:0]          o_rd_sel;
    logic                o_window_valid;
    logic                o_intr;

    line_buffer_sched dut (
        .axi_clk        (axi_clk),
        .axi_reset      (axi_reset),
        .i_pixel_valid  (i_pixel_valid),
        .o_in_ready     (o_in_ready),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .i_out_ready    (i_out_ready),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .o_rd_sel       (o_rd_sel),
        .o_window_valid (o_window_valid),
        .o_intr         (o_intr)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct packed {
        logic              in_ready;
        logic [3:0]        wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [3:0]        rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic [1:0]        rd_sel;
        logic              wv;
        logic              intr;
    } obs_t;

    typedef struct {
        bit                v;
        bit                r;
        logic [3:0]        wr_en;
        logic [ADDR_W-1:0] wr_addr;
        bit                in_ready;
        logic [3:0]        rd_en;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: everything follows from total pixels written and total beats read.
    int m_fill, m_wc, m_bc;
    bit m_active, m_wv, m_intr;

    int                intr_seen, beats_seen;
    bit                first_got;
    logic [3:0]        first_rd_en;
    logic [ADDR_W-1:0] first_rd_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill = 0; m_wc = 0; m_bc = 0;
        m_active = 0; m_wv = 0; m_intr = 0;
    endtask

    function automatic obs_t expect_obs(input bit v, input bit r);
        obs_t e;
        bit   acc, beat;
        e.in_ready = (m_fill < 4 * LW);
        acc        = v && e.in_ready;
        beat       = m_active && r;
        e.wr_en    = '0;
        if (acc) e.wr_en[(m_wc / LW) % 4] = 1'b1;
        e.wr_addr  = ADDR_W'(m_wc % LW);
        e.rd_en    = '0;
        if (beat) for (int k = 0; k < 3; k++) e.rd_en[((m_bc / LW) + k) % 4] = 1'b1;
        e.rd_addr  = ADDR_W'(m_bc % LW);
        e.rd_sel   = 2'((m_bc / LW) % 4);
        e.wv       = m_wv;
        e.intr     = m_intr;
        return e;
    endfunction

    task automatic model_edge(input bit v, input bit r);
        bit acc, beat, last;
        acc  = v && (m_fill < 4 * LW);
        beat = m_active && r;
        last = beat && ((m_bc % LW) == LW - 1);
        m_wv   = beat;
        m_intr = last;
        if (m_active) begin
            if (last) m_active = 0;
        end else if (m_fill >= 3 * LW) begin
            m_active = 1;
        end
        m_fill = m_fill + int'(acc) - int'(beat);
        m_wc   = m_wc + int'(acc);
        m_bc   = m_bc + int'(beat);
    endtask

    task automatic step(input bit v, input bit r);
        obs_t e, a;
        i_pixel_valid = v;
        i_out_ready   = r;
        @(negedge axi_clk);
        e = expect_obs(v, r);
        a = {o_in_ready, o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_rd_sel, o_window_valid, o_intr};
        chk("cycle_outputs", 64'(a), 64'(e));
        if (o_intr) intr_seen++;
        if (o_rd_en != 4'b0000) begin
            beats_seen++;
            if (!first_got) begin
                first_got     = 1;
                first_rd_en   = o_rd_en;
                first_rd_addr = o_rd_addr;
            end
        end
        @(posedge axi_clk);
        model_edge(v, r);
        #1;
    endtask

    task automatic clear_counts();
        intr_seen = 0; beats_seen = 0; first_got = 0;
        first_rd_en = '0; first_rd_addr = '0;
    endtask

    // Reset asserted mid-cycle; outputs must settle before any clock edge.
    task automatic do_reset();
        i_pixel_valid = 0;
        i_out_ready   = 0;
        #2 axi_reset = 1'b1;
        #1;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_wv", o_window_valid, 0);
        chk("rst_intr", o_intr, 0);
        chk("rst_addrs", {o_wr_addr, o_rd_addr, o_rd_sel}, 0);
        model_reset();
        @(posedge axi_clk);
        #1 axi_reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1, 1, 4'b0001, 0, 1, 4'b0000};
        vecs[1] = '{0, 1, 4'b0000, 1, 1, 4'b0000};
        vecs[2] = '{1, 0, 4'b0001, 1, 1, 4'b0000};
        vecs[3] = '{1, 1, 4'b0001, 2, 1, 4'b0000};
        vecs[4] = '{0, 0, 4'b0000, 3, 1, 4'b0000};
        vecs[5] = '{1, 1, 4'b0001, 3, 1, 4'b0000};

        #1;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            i_pixel_valid = vecs[i].v;
            i_out_ready   = vecs[i].r;
            @(negedge axi_clk);
            chk("vec_wr_en", o_wr_en, vecs[i].wr_en);
            chk("vec_wr_addr", o_wr_addr, vecs[i].wr_addr);
            chk("vec_in_ready", o_in_ready, vecs[i].in_ready);
            chk("vec_rd_en", o_rd_en, vecs[i].rd_en);
            @(posedge axi_clk);
            #1;
        end
        do_reset();

        // Three lines back-to-back, then the first window line drains.
        repeat (3 * LW) step(1, 1);
        clear_counts();
        repeat (LW + 3) step(0, 1);
        chk("line1_beats", beats_seen, LW);
        chk("line1_intr", intr_seen, 1);
        chk("line1_first_rd_en", first_rd_en, 4'b0111);
        chk("line1_first_rd_addr", first_rd_addr, 0);
        chk("line1_rd_sel_after", o_rd_sel, 1);

        // One more line, then read it out with alternating backpressure.
        repeat (LW) step(1, 0);
        clear_counts();
        for (int i = 0; i < 2 * LW + 8; i++) step(0, (i % 2) == 0);
        chk("bp_beats", beats_seen, LW);
        chk("bp_intr", intr_seen, 1);
        chk("bp_first_rd_en", first_rd_en, 4'b1110);

        // Fill the bank completely with the reader stalled.
        repeat (2 * LW + 2) step(1, 0);
        chk("full_in_ready", o_in_ready, 0);
        i_pixel_valid = 1;
        i_out_ready   = 0;
        #1;
        chk("full_wr_en", o_wr_en, 0);
        step(1, 1);
        chk("full_reraised", o_in_ready, 1);

        // Simultaneous write and beat leave the fill level at one below full.
        repeat (10) step(1, 1);
        chk("simul_in_ready", o_in_ready, 1);
        step(1, 0);
        chk("simul_then_full", o_in_ready, 0);

        // Abandon a line at beat 200 with reset.
        clear_counts();
        repeat (189) step(0, 1);
        chk("pre_reset_intr", intr_seen, 0);
        do_reset();
        repeat (3 * LW) step(1, 0);
        clear_counts();
        repeat (4) step(0, 1);
        chk("post_reset_first_rd_en", first_rd_en, 4'b0111);
        chk("post_reset_first_rd_addr", first_rd_addr, 0);
        chk("post_reset_no_intr", intr_seen, 0);

        // Random traffic.
        repeat (4000) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buffer_sched.md
# line_buffer_sched

Controller that sequences the four-line pixel buffer bank ahead of the 3x3 edge-detection kernels. It accepts the incoming pixel stream, generates write enables and addresses into a rotating set of four line buffers, and starts a three-row window readout once three full lines are stored. After each completed output line it frees one buffer and pulses an interrupt so the host DMA sends the next line.

## Interface
- LINE_WIDTH, 512, pixels per line. Must be a power of two, ≥4.
- NUM_BUFS, 4, line buffers in the bank. This block supports only 4.
- axi_clk  in  1  single clock; all logic is rising-edge.
- axi_reset  in  1  asynchronous, active-high reset.
- i_pixel_valid  in  1  input pixel strobe. Pixel data goes straight to the buffers, not through this block.
- o_in_ready  out  1  high when a write can be accepted: fill_cnt < NUM_BUFS*LINE_WIDTH.
- o_wr_en  out  4  one-hot write enable, bit = wr_buf. Equals i_pixel_valid && o_in_ready.
- o_wr_addr  out  $clog2(LINE_WIDTH)  write pixel index within the line.
- i_out_ready  in  1  downstream kernel ready; read beats occur only when high.
- o_rd_en  out  4  read enables for rows rd_buf, rd_buf+1 and rd_buf+2 (mod 4).
- o_rd_addr  out  $clog2(LINE_WIDTH)  read pixel index.
- o_rd_sel  out  2  rd_buf, the index of the top window row, used by the downstream row mux.
- o_window_valid  out  1  registered; high one cycle after each read beat.
- o_intr  out  1  one-cycle pulse per completed output line.

## Operation
- Write side
  - Write accept = i_pixel_valid && o_in_ready.
  - On accept, wr_addr increments. At LINE_WIDTH-1 it wraps to 0 and wr_buf increments mod 4.
- fill_cnt, width $clog2(4*LINE_WIDTH)+1
  - Incremented by a write accept and decremented by a read beat.
  - A write and a read beat in the same cycle leave it unchanged.
- Read FSM, two states
  - IDLE: transitions to ACTIVE when fill_cnt ≥ 3*LINE_WIDTH.
  - ACTIVE: a read beat = i_out_ready. On a beat, o_rd_en = rotl(4'b0111, rd_buf) and rd_addr increments.
  - A beat at rd_addr = LINE_WIDTH-1 sets rd_addr to 0, increments rd_buf mod 4, returns to IDLE, and registers o_intr high for one cycle.
- o_rd_en is all-zero outside beats. Combinational paths: o_rd_en from state, rd_buf and i_out_ready; o_wr_en from i_pixel_valid and fill_cnt.
- Safety argument: one read beat frees one slot of buffer rd_buf at the same index. A write to buffer rd_buf therefore never overtakes the read pointer, because fill_cnt is capped at 4*LINE_WIDTH.
- Reset, asynchronous and immediate:
  - fill_cnt, wr_buf, wr_addr, rd_buf, rd_addr = 0; state = IDLE.
  - o_window_valid = 0, o_intr = 0, o_rd_en = 0, o_in_ready = 1.
  - An in-progress line is abandoned; the next line starts at buffer 0.

## Timing
- IDLE→ACTIVE takes one cycle after the cycle in which fill_cnt reaches 3*LINE_WIDTH. The first beat can occur in the first ACTIVE cycle.
- o_window_valid follows each beat by exactly 1 cycle, matching the line buffers' 1-cycle read latency.
- o_intr is high the cycle after the last beat of a line. The FSM is in IDLE in that cycle and may re-enter ACTIVE on the next cycle if fill_cnt still qualifies.
- With i_out_ready held high, a line takes LINE_WIDTH beats with no gaps.
- Full condition: fill_cnt = 2048 (default parameters) forces o_in_ready low. A valid pixel in that cycle is dropped, and wr_addr and fill_cnt are unchanged.
- Empty: fill_cnt never underflows, because beats occur only in ACTIVE and ACTIVE requires ≥3 lines.

## Structure
- Shared package img_pkg: LINE_WIDTH, NUM_BUFS, derived address width, and the read FSM state enum (RD_IDLE, RD_ACTIVE). The package is shared with the line buffer and kernel blocks.
- One sub-module, ring_ptr: a (buffer index, pixel address) counter that advances on an enable, wraps the address at LINE_WIDTH-1 and the buffer at NUM_BUFS-1. It is instantiated twice, once for the write side and once for the read side.

## Test plan
- Reset: assert axi_reset mid-cycle → all outputs are at reset values immediately; o_in_ready = 1.
- Write 1536 pixels back-to-back with i_out_ready = 1:
  - o_wr_en steps 0001→0010→0100 every 512 writes.
  - The FSM enters ACTIVE the cycle after write 1536, with o_rd_en = 0111 and o_rd_addr = 0.
  - o_window_valid is high 1 cycle later.
- Complete one line (512 beats) → o_intr pulses once for exactly 1 cycle; o_rd_sel = 1; the next line's o_rd_en = 1110.
- Backpressure: toggle i_out_ready 1/0 every cycle → beats and o_window_valid occur on alternate cycles, and the line still completes with 512 beats.
- Full: write 2048 pixels with i_out_ready = 0 → o_in_ready = 0 and a 2049th valid pixel is not accepted (o_wr_en = 0). One beat then re-raises o_in_ready.
- Simultaneous write and beat, plus reset during ACTIVE:
  - Simultaneous write + beat → fill_cnt unchanged.
  - Reset at beat 200 → the FSM returns to IDLE, there is no o_intr, and after refill the first o_rd_en = 0111.
